iter_muldiv_16: RTL and testbench
=================================

Name: iter_muldiv_16

Overview:
- Multi-cycle integer multiply/divide execute unit. Sits directly downstream of the 16x16 register file.
- Consumes the two read operands (rd1/rd2) plus a destination register address.
- Produces a 16-bit result and the destination address for the write-back path into the register file.
- Iterative: one shift-add or shift-subtract step per clock. Valid/ready handshake on both sides.

Parameters:
WIDTH, 16, operand/result width; iteration count equals WIDTH
ADDR_W, 4, destination register address width (16 registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  [1:0]: 00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder; [2]: signed (see Optional Feature)
a  input  WIDTH  operand A (multiplicand / dividend), from rd1
b  input  WIDTH  operand B (multiplier / divisor), from rd2
dst  input  ADDR_W  destination register address, passed through
out_valid  output  1  result valid
out_ready  input  1  write-back stage accepts result
res  output  WIDTH  result
res_dst  output  ADDR_W  latched dst of the operation
div_by_zero  output  1  set with result when a DIV op had b == 0
busy  output  1  high in RUN or DONE

Behaviour:
- Reset:
  - state=IDLE, counter=0, internal accumulators=0.
  - Outputs after reset: in_ready=1, out_valid=0, res=0, res_dst=0, div_by_zero=0, busy=0.
  - rst has priority over every other event, including mid-RUN and DONE. An in-flight operation is discarded with no result.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b, op, dst; clear the counter; go to RUN.
- RUN:
  - One iteration per clock; counter increments each step.
  - After the step with counter==WIDTH-1, go to DONE.
  - Exactly WIDTH RUN cycles.
  - in_valid is ignored in RUN and DONE.
- MUL: shift-add over a 2*WIDTH product.
  - op 00 returns product[WIDTH-1:0].
  - op 01 returns product[2*WIDTH-1:WIDTH].
- DIV: restoring division.
  - op 10 returns the quotient.
  - op 11 returns the remainder.
- Divide by zero:
  - Takes the same WIDTH cycles with no special path; the natural restoring result is used.
  - quotient=all ones (0xFFFF), remainder=a.
  - div_by_zero=1. For MUL ops div_by_zero=0.
- DONE:
  - out_valid=1; res, res_dst, div_by_zero held stable until out_ready.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle.
  - No back-to-back overlap: a new request is accepted no earlier than the cycle after the result handshake.
- Latency:
  - Request accepted at edge E0; out_valid is high from edge E0+WIDTH (16 cycles).
  - Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- out_ready high while out_valid=0 has no effect.
- res/res_dst/div_by_zero keep their last values after the handshake until the next result.

Optional Feature:
- Macro: ITER_MULDIV_SIGNED_EN.
- When defined, op[2]=1 selects signed two's-complement:
  - Operands are converted to magnitudes and the unsigned engine is used; results are sign-corrected in the final RUN cycle, so latency is unchanged.
  - MUL high is the signed high half.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0x0000, div_by_zero=0.
  - Signed divide by zero gives quotient 0xFFFF, remainder=a, div_by_zero=1.
- When not defined, op[2] is ignored and all ops are unsigned. No sign-correction logic is instantiated.

Test Plan:
- MUL: a=0x1234, b=0x0010.
  - op 00 -> res=0x2340.
  - op 01 -> res=0x0001.
  - res_dst equals the dst given; out_valid rises exactly 16 cycles after acceptance.
- MUL high: a=0xFFFF, b=0xFFFF, op 01 -> res=0xFFFE; op 00 -> res=0x0001.
- DIV: a=100, b=7.
  - op 10 -> res=14.
  - op 11 -> res=2.
  - div_by_zero=0.
- Divide by zero: a=0x1234, b=0.
  - op 10 -> res=0xFFFF, div_by_zero=1.
  - op 11 -> res=0x1234.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> res/res_dst stable, in_ready=0, in_valid pulses ignored.
  - Raising out_ready completes the handshake; in_ready=1 on the following cycle.
  - Separately, assert rst at RUN step 7 -> IDLE, out_valid never asserts, in_ready=1 after reset.
- Signed (ITER_MULDIV_SIGNED_EN):
  - a=0xFFF9 (-7), b=0x0002, op 110 -> 0xFFFD; op 111 -> 0xFFFF.
  - a=0x8000, b=0xFFFF, op 110 -> 0x8000.

Source files
------------

// File: rtl/iter_muldiv_16.sv
// Iterative multiply/divide unit: one shift-add (MUL) or restoring shift-subtract (DIV) step per clock.
// Optional signed operation (op[2]) is compiled in with `define ITER_MULDIV_SIGNED_EN.
module iter_muldiv_16 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  res,
  output logic [ADDR_W-1:0] res_dst,
  output logic              div_by_zero,
  output logic              busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;
  logic [WIDTH-1:0]    mcand;
  logic [1:0]          op_r;
  logic [ADDR_W-1:0]   dst_r;
  logic                dz_r;

  logic [WIDTH-1:0]    hi_n, lo_n, raw, res_fin;
  logic [WIDTH:0]      sum, rem_try;
  logic [WIDTH-1:0]    rem_sub;
  logic                ge;
  logic [WIDTH-1:0]    a_mag, b_mag;

  // hi:lo is the product (MUL) or remainder:dividend/quotient (DIV)
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    rem_try = {hi, lo[WIDTH-1]};
    ge      = rem_try >= {1'b0, mcand};
    rem_sub = rem_try[WIDTH-1:0] - mcand;
    hi_n    = '0;
    lo_n    = '0;
    if (op_r[1]) begin
      hi_n = ge ? rem_sub : rem_try[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
    raw = op_r[0] ? hi_n : lo_n;
  end

`ifdef ITER_MULDIV_SIGNED_EN
  logic neg_r;
  logic sa, sb, neg_in;

  // High half of a negated double-width product borrows only when the low half is zero
  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] lo_part,
                                                input logic [1:0]       opc,
                                                input logic             neg);
    if (!neg)
      return r;
    if (opc == 2'b01)
      return ~r + {{(WIDTH-1){1'b0}}, (lo_part == '0)};
    return ~r + ONE;
  endfunction

  always_comb begin
    sa     = op[2] & a[WIDTH-1];
    sb     = op[2] & b[WIDTH-1];
    a_mag  = sa ? (~a + ONE) : a;
    b_mag  = sb ? (~b + ONE) : b;
    neg_in = op[1] ? (op[0] ? sa : ((sa ^ sb) & (b != '0))) : (sa ^ sb);
  end

  assign res_fin = sign_fix(raw, lo_n, op_r, neg_r);

  always_ff @(posedge clk) begin
    if (rst)
      neg_r <= 1'b0;
    else if (state == IDLE && in_valid)
      neg_r <= neg_in;
  end
`else
  logic unused_sign;
  assign unused_sign = op[2];
  assign a_mag   = a;
  assign b_mag   = b;
  assign res_fin = raw;
  logic unused_one;
  assign unused_one = ONE[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      op_r        <= '0;
      dst_r       <= '0;
      dz_r        <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      res         <= '0;
      res_dst     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hi       <= '0;
            lo       <= op[1] ? a_mag : b_mag;
            mcand    <= op[1] ? b_mag : a_mag;
            op_r     <= op[1:0];
            dst_r    <= dst;
            dz_r     <= op[1] & (b == '0);
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            res         <= res_fin;
            res_dst     <= dst_r;
            div_by_zero <= dz_r;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_16.sv
// Randomized self-checking bench for iter_muldiv_16 against an arithmetic reference model.
module tb_iter_muldiv_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic [3:0]  dst;
  logic        out_valid, out_ready;
  logic [15:0] res;
  logic [3:0]  res_dst;
  logic        div_by_zero, busy;

  iter_muldiv_16 #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .dst(dst), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_dst(res_dst), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  d;
    logic        z;
  } exp_t;

  exp_t expq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic [2:0] mop, output logic [15:0] r, output logic z);
    logic [31:0] p;
    int sa, sb, q, rm;
    logic sg;
    sg = 1'b0;
`ifdef ITER_MULDIV_SIGNED_EN
    sg = mop[2];
`endif
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    z  = mop[1] && (mb == 16'h0);
    if (!mop[1]) begin
      if (sg) begin
        q = sa * sb;
        p = q;
      end else begin
        p = {16'h0, ma} * {16'h0, mb};
      end
      r = mop[0] ? p[31:16] : p[15:0];
    end else if (mb == 16'h0) begin
      r = mop[0] ? ma : 16'hFFFF;
    end else if (sg) begin
      q  = sa / sb;
      rm = sa % sb;
      r  = mop[0] ? rm[15:0] : q[15:0];
    end else begin
      r = mop[0] ? (ma % mb) : (ma / mb);
    end
  endfunction

  // Result checker: every cycle a result is presented it must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        chk("res", res, expq[0].r);
        chk("res_dst", res_dst, expq[0].d);
        chk("div_by_zero", div_by_zero, expq[0].z);
        chk("ready_busy_in_done", {in_ready, busy}, 2'b01);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] top,
                       input logic [3:0] tdst, input int hold, input logic early,
                       input logic use_lit, input logic [15:0] lit);
    exp_t e;
    logic [15:0] mr;
    logic mz;
    int k;
    model(ta, tb, top, mr, mz);
    if (use_lit) chk("model_pin", mr, lit);
    k = 0;
    while (!in_ready && k < 30) begin
      @(posedge clk); #1; k++;
    end
    chk("in_ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1; a = ta; b = tb; op = top; dst = tdst; out_ready = early;
    @(posedge clk); #1;
    e.r = use_lit ? lit : mr; e.d = tdst; e.z = mz;
    expq.push_back(e);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); dst = 4'($urandom); op = 3'($urandom);
    chk("busy_after_accept", {in_ready, busy, out_valid}, 3'b010);
    k = 0;
    while (!out_valid && k < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1; k++;
    end
    chk("latency", k, 16);
    if (early) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk("idle_after_handshake", {in_ready, busy, out_valid}, 3'b100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = 16'h0; b = 16'h0; dst = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, out_valid, busy, div_by_zero, res_dst, res}, {4'b1000, 4'h0, 16'h0});
    rst = 1'b0;

    issue(16'h1234, 16'h0010, 3'b000, 4'h3, 5, 1'b0, 1'b1, 16'h2340);
    issue(16'h1234, 16'h0010, 3'b001, 4'h5, 0, 1'b1, 1'b1, 16'h0001);
    issue(16'hFFFF, 16'hFFFF, 3'b001, 4'hA, 1, 1'b0, 1'b1, 16'hFFFE);
    issue(16'hFFFF, 16'hFFFF, 3'b000, 4'hB, 0, 1'b0, 1'b1, 16'h0001);
    issue(16'd100,  16'd7,    3'b010, 4'h1, 2, 1'b0, 1'b1, 16'd14);
    issue(16'd100,  16'd7,    3'b011, 4'h2, 0, 1'b1, 1'b1, 16'd2);
    issue(16'h1234, 16'h0000, 3'b010, 4'hE, 0, 1'b0, 1'b1, 16'hFFFF);
    issue(16'h1234, 16'h0000, 3'b011, 4'hF, 3, 1'b0, 1'b1, 16'h1234);
`ifdef ITER_MULDIV_SIGNED_EN
    issue(16'hFFF9, 16'h0002, 3'b110, 4'h4, 0, 1'b1, 1'b1, 16'hFFFD);
    issue(16'hFFF9, 16'h0002, 3'b111, 4'h6, 0, 1'b0, 1'b1, 16'hFFFF);
    issue(16'h8000, 16'hFFFF, 3'b110, 4'h7, 0, 1'b1, 1'b1, 16'h8000);
    issue(16'h8000, 16'hFFFF, 3'b111, 4'h8, 0, 1'b1, 1'b1, 16'h0000);
    issue(16'hFFF9, 16'h0000, 3'b110, 4'h9, 0, 1'b1, 1'b1, 16'hFFFF);
    issue(16'hFFF9, 16'h0000, 3'b111, 4'h9, 0, 1'b1, 1'b1, 16'hFFF9);
    issue(16'hFFFE, 16'h0003, 3'b101, 4'hC, 0, 1'b1, 1'b1, 16'hFFFF);
`else
    issue(16'h1234, 16'h0010, 3'b100, 4'h4, 0, 1'b1, 1'b1, 16'h2340);
    issue(16'hFFF9, 16'h0002, 3'b110, 4'h6, 0, 1'b1, 1'b1, 16'h7FFC);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0;
        1: ra = 16'h8000;
        2: rb = 16'hFFFF;
        3: rb = 16'($urandom_range(1, 15));
        default: ;
      endcase
      issue(ra, rb, 3'($urandom), 4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 16'h0);
    end

    // Abort mid-RUN: reset discards the operation with no result
    in_valid = 1'b1; a = 16'h4321; b = 16'h0003; op = 3'b000; dst = 4'hD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_mid_run", {in_ready, out_valid, busy, div_by_zero, res_dst, res}, {4'b1000, 4'h0, 16'h0});
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("no_valid_after_abort", {in_ready, out_valid}, 2'b10);
    end

    issue(16'd1000, 16'd33, 3'b010, 4'h2, 0, 1'b0, 1'b1, 16'd30);
    chk("queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
